sdram_dev_resp: RTL
===================

Name: sdram_dev_resp

Overview:
Synthesizable SDRAM device-side responder: the chip end of the command/DQ interface that sdram_mac drives. It decodes CSn/RASn/CASn/WEn commands, tracks open rows per bank, holds the mode register, and serves read and write bursts from a small internal 16-bit array with CAS-latency-accurate timing. It is used as an on-chip loopback target for controller bring-up, and as a protocol checker through its error outputs.

Parameters:
COL_W, 9, SDRAM column address width; full-page burst length is 2^COL_W.
MEM_ROW_W, 2, low row bits stored in the backing array.
MEM_COL_W, 6, low column bits stored in the backing array.

Ports:
CLK  in  1  clock; all inputs sampled on rising edge.
RESETn  in  1  asynchronous active-low reset.
CKE  in  1  clock enable; low = suspend.
CSn  in  1  chip select, active low.
RASn, CASn, WEn  in  1 each  command strobes, active low.
BA  in  2  bank address.
A  in  13  row/column/mode address; A[10] = auto-precharge / precharge-all.
DQML, DQMH  in  1 each  byte masks.
DQ_I  in  16  write data from the bus.
DQ_O  out  16  read data to the bus.
DQ_OE  out  1  drive enable for DQ_O.
MODE_OK  out  1  a valid LOAD MODE has been accepted.
ERR  out  1  one-cycle pulse on a protocol violation.
ERR_CNT  out  8  saturating count of ERR pulses.
REF_CNT  out  16  wrapping count of AUTO REFRESH commands.

Behaviour:
- Reset:
  - DQ_O=0, DQ_OE=0, MODE_OK=0, ERR=0, ERR_CNT=0, REF_CNT=0.
  - All banks closed, no burst active, read pipeline empty.
  - Array contents are not reset.
- Command decode:
  - A command is decoded only when CKE=1 and CSn=0; otherwise it is a NOP.
  - {RASn,CASn,WEn}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE.
- LOAD MODE:
  - A[2:0] selects BL: 0→1, 1→2, 2→4, 3→8, 7→2^COL_W.
  - A[6:4] selects CL: 2 or 3.
  - Any other BL/CL value raises ERR and leaves the mode register unchanged.
  - A valid write sets MODE_OK=1.
- ACTIVE: opens BA with row A; ERR if the bank is already open.
- PRECHARGE:
  - Closes BA, or all banks if A[10]=1.
  - Terminates an active burst whose bank is being closed.
- READ/WRITE:
  - ERR if MODE_OK=0 or the bank is closed; the command is then ignored.
  - Start column = A[COL_W-1:0].
  - Bursts are sequential and wrap within the BL-aligned block (full page wraps over 2^COL_W).
  - A[10]=1 closes the bank after the last beat.
- Array index = {BA, row[MEM_ROW_W-1:0], col[MEM_COL_W-1:0]}.
- Write:
  - Beat 0 DQ_I is sampled in the same cycle as the WRITE command; beat k is sampled k cycles later.
  - DQML/DQMH sampled with each beat gate bytes [7:0]/[15:8] (DQM=1 means no write).
- Read:
  - Beat k for READ issued in cycle t appears on DQ_O with DQ_OE=1 in cycle t+CL+k (registered outputs).
  - Read DQM latency is 2: DQ_OE for a beat is 0 if DQML&DQMH were both 1 two cycles before that beat's output cycle.
- Burst interruption:
  - READ, WRITE, or BURST TERMINATE during a burst stops column generation immediately; the new command takes effect in that same cycle.
  - Read beats already issued into the CL pipeline still emerge.
  - A command in the cycle of the last beat starts back-to-back with no gap.
- AUTO REFRESH: increments REF_CNT; ERR if any bank is open.
- ERR/ERR_CNT: ERR is high for exactly 1 cycle per violation; ERR_CNT saturates at 255.
- CKE=0: burst counters, read pipeline, DQ_O and DQ_OE are all frozen; no array writes occur.
- RESETn asserted mid-burst: DQ_OE=0 immediately and all state returns to reset values.

Test Plan:
1. Reset, then LOAD MODE A=0x032 (CL3, BL4) -> MODE_OK=1 next cycle, ERR=0.
2. ACTIVE BA=0 row 0; WRITE col 0x10 with DQ_I 1,2,3,4 in consecutive cycles; READ col 0x10 at cycle t -> DQ_O=1,2,3,4 in cycles t+3..t+6 with DQ_OE=1.
3. WRITE col 0x12 (BL4) -> beats land at 0x12,0x13,0x10,0x11 (wrap); read back matches.
4. LOAD MODE BL=8 CL=2; READ col 0x20; BURST TERMINATE 3 cycles later -> exactly 3 beats, first at t+2; DQ_OE=0 afterwards.
5. READ to a closed bank; ACTIVE to an open bank; LOAD MODE with CL=1 -> three ERR pulses, ERR_CNT=3, mode unchanged.
6. Write with DQMH=1 on beat 1 -> upper byte of that word keeps its old value; CKE low for 2 cycles mid-read -> read burst output delayed by 2 cycles, no beats lost.

Source files
------------

// File: rtl/sdram_dev_resp.sv
// SDRAM chip-side responder: decodes the command bus, tracks open rows, holds the mode
// register and serves CAS-latency-accurate read/write bursts from a small internal array.
module sdram_dev_resp #(
   parameter int COL_W     = 9,
   parameter int MEM_ROW_W = 2,
   parameter int MEM_COL_W = 6
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        CKE,
   input  logic        CSn,
   input  logic        RASn,
   input  logic        CASn,
   input  logic        WEn,
   input  logic [1:0]  BA,
   input  logic [12:0] A,
   input  logic        DQML,
   input  logic        DQMH,
   input  logic [15:0] DQ_I,
   output logic [15:0] DQ_O,
   output logic        DQ_OE,
   output logic        MODE_OK,
   output logic        ERR,
   output logic [7:0]  ERR_CNT,
   output logic [15:0] REF_CNT
);

   localparam int MEM_AW = 2 + MEM_ROW_W + MEM_COL_W;

   typedef enum logic [2:0] {
      CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE,
      CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE, CMD_BST
   } cmd_t;

   typedef enum logic [1:0] {BURST_IDLE, BURST_READ, BURST_WRITE} burst_t;

   cmd_t                 cmd;
   burst_t               state, state_next;

   logic [15:0]          mem [0:(1<<MEM_AW)-1];
   logic [3:0]           bank_open;
   logic [MEM_ROW_W-1:0] bank_row [0:3];
   logic [COL_W-1:0]     bl_mask;
   logic                 cl3;

   logic [1:0]           burst_bank;
   logic [MEM_ROW_W-1:0] burst_row;
   logic [COL_W-1:0]     burst_col;
   logic [COL_W-1:0]     beats_left;
   logic                 burst_ap;

   logic                 s1_valid, s2_valid;
   logic [MEM_AW-1:0]    s1_addr, s2_addr;
   logic                 dqm_d1;
   logic                 out_valid;
   logic [MEM_AW-1:0]    out_addr;

   logic                 lm_ok, bl_ok;
   logic [COL_W-1:0]     lm_mask;
   logic                 rw_ok, new_start, kill, err_now;
   logic                 beat_valid, beat_write;
   logic [1:0]           beat_bank;
   logic [MEM_ROW_W-1:0] beat_row;
   logic [COL_W-1:0]     beat_col;
   logic [MEM_AW-1:0]    beat_addr;
   logic                 ap_close;
   logic [1:0]           ap_bank;
   logic                 unused_bits;

   // Sequential wrap inside the BL-aligned block; the mask is BL-1.
   function automatic logic [COL_W-1:0] wrap_next(input logic [COL_W-1:0] c,
                                                  input logic [COL_W-1:0] m);
      return (c & ~m) | ((c + 1'b1) & m);
   endfunction

   always_comb begin
      cmd = CMD_NOP;
      if (CKE && !CSn) begin
         case ({RASn, CASn, WEn})
            3'b011:  cmd = CMD_ACTIVE;
            3'b101:  cmd = CMD_READ;
            3'b100:  cmd = CMD_WRITE;
            3'b010:  cmd = CMD_PRECHARGE;
            3'b001:  cmd = CMD_REFRESH;
            3'b000:  cmd = CMD_LOAD_MODE;
            3'b110:  cmd = CMD_BST;
            default: cmd = CMD_NOP;
         endcase
      end
   end

   always_comb begin
      lm_mask = '0;
      bl_ok   = 1'b1;
      case (A[2:0])
         3'd0:    lm_mask = '0;
         3'd1:    lm_mask = COL_W'(1);
         3'd2:    lm_mask = COL_W'(3);
         3'd3:    lm_mask = COL_W'(7);
         3'd7:    lm_mask = '1;
         default: bl_ok   = 1'b0;
      endcase
      lm_ok = bl_ok && (A[6:4] == 3'd2 || A[6:4] == 3'd3);
   end

   assign rw_ok     = MODE_OK && bank_open[BA];
   assign new_start = (cmd == CMD_READ || cmd == CMD_WRITE) && rw_ok;
   assign kill      = new_start || (cmd == CMD_BST) ||
                      (cmd == CMD_PRECHARGE && (A[10] || BA == burst_bank));

   always_comb begin
      err_now = 1'b0;
      case (cmd)
         CMD_LOAD_MODE:        err_now = !lm_ok;
         CMD_ACTIVE:           err_now = bank_open[BA];
         CMD_READ, CMD_WRITE:  err_now = !rw_ok;
         CMD_REFRESH:          err_now = |bank_open;
         default:              err_now = 1'b0;
      endcase
   end

   // A new READ/WRITE supplies beat 0 itself; later beats come from the burst registers.
   always_comb begin
      state_next = state;
      beat_valid = 1'b0;
      beat_write = 1'b0;
      beat_bank  = '0;
      beat_row   = '0;
      beat_col   = '0;
      ap_close   = 1'b0;
      ap_bank    = '0;
      if (new_start) begin
         beat_valid = 1'b1;
         beat_write = (cmd == CMD_WRITE);
         beat_bank  = BA;
         beat_row   = bank_row[BA];
         beat_col   = A[COL_W-1:0];
         if (bl_mask == '0) begin
            state_next = BURST_IDLE;
            ap_close   = A[10];
            ap_bank    = BA;
         end else begin
            state_next = (cmd == CMD_WRITE) ? BURST_WRITE : BURST_READ;
         end
      end else if (CKE && state != BURST_IDLE) begin
         if (kill) begin
            state_next = BURST_IDLE;
         end else begin
            beat_valid = 1'b1;
            beat_write = (state == BURST_WRITE);
            beat_bank  = burst_bank;
            beat_row   = burst_row;
            beat_col   = burst_col;
            if (beats_left == COL_W'(1)) begin
               state_next = BURST_IDLE;
               ap_close   = burst_ap;
               ap_bank    = burst_bank;
            end
         end
      end
   end

   assign beat_addr   = {beat_bank, beat_row, beat_col[MEM_COL_W-1:0]};
   assign out_valid   = cl3 ? s2_valid : s1_valid;
   assign out_addr    = cl3 ? s2_addr  : s1_addr;
   assign unused_bits = ^{A, beat_col};

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state <= BURST_IDLE;
      else         state <= state_next;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         burst_bank <= '0;
         burst_row  <= '0;
         burst_col  <= '0;
         beats_left <= '0;
         burst_ap   <= 1'b0;
      end else if (new_start) begin
         burst_bank <= BA;
         burst_row  <= bank_row[BA];
         burst_col  <= wrap_next(A[COL_W-1:0], bl_mask);
         beats_left <= bl_mask;
         burst_ap   <= A[10];
      end else if (beat_valid) begin
         burst_col  <= wrap_next(burst_col, bl_mask);
         beats_left <= beats_left - 1'b1;
      end
   end

   // Auto-precharge is applied before the command so an explicit command wins.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         bank_open <= '0;
         for (int i = 0; i < 4; i++) bank_row[i] <= '0;
         bl_mask   <= '0;
         cl3       <= 1'b0;
         MODE_OK   <= 1'b0;
         ERR       <= 1'b0;
         ERR_CNT   <= '0;
         REF_CNT   <= '0;
      end else begin
         ERR <= err_now;
         if (err_now && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
         if (ap_close) bank_open[ap_bank] <= 1'b0;
         case (cmd)
            CMD_ACTIVE: begin
               if (!bank_open[BA]) begin
                  bank_open[BA] <= 1'b1;
                  bank_row[BA]  <= A[MEM_ROW_W-1:0];
               end
            end
            CMD_PRECHARGE: begin
               if (A[10]) bank_open     <= '0;
               else       bank_open[BA] <= 1'b0;
            end
            CMD_REFRESH: REF_CNT <= REF_CNT + 16'd1;
            CMD_LOAD_MODE: begin
               if (lm_ok) begin
                  bl_mask <= lm_mask;
                  cl3     <= (A[6:4] == 3'd3);
                  MODE_OK <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (beat_valid && beat_write) begin
         if (!DQML) mem[beat_addr][7:0]  <= DQ_I[7:0];
         if (!DQMH) mem[beat_addr][15:8] <= DQ_I[15:8];
      end
   end

   // Read addresses travel down a two-stage CL pipeline; CL2 taps stage 1, CL3 stage 2.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         dqm_d1   <= 1'b0;
         DQ_O     <= '0;
         DQ_OE    <= 1'b0;
      end else if (CKE) begin
         s1_valid <= beat_valid && !beat_write;
         s1_addr  <= beat_addr;
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         dqm_d1   <= DQML & DQMH;
         DQ_O     <= out_valid ? mem[out_addr] : '0;
         DQ_OE    <= out_valid && !dqm_d1;
      end
   end

endmodule
